// File: rtl/tri_hit_pkg.sv
// Shared types for the per-triangle hit counter: report record layout and
// subsample-mode decode.
package tri_hit_pkg;

  localparam int unsigned REC_SIGFIG = 24;
  localparam int unsigned REC_VERTS  = 3;
  localparam int unsigned REC_CNT_W  = 16;

  localparam logic [REC_CNT_W-1:0] CNT_MAX = '1;

  typedef logic [REC_VERTS-1:0][1:0][REC_SIGFIG-1:0] tri_t;

  // count is sized for the widest counter; narrower instances zero-extend
  typedef struct packed {
    tri_t                 vtx;
    logic [REC_CNT_W-1:0] count;
    logic [1:0]           ss_w_lg2;
    logic                 sat;
  } tri_hit_rec_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] lg2;
  } ss_dec_t;

  function automatic ss_dec_t ss_decode(input logic [3:0] ss);
    ss_dec_t d;
    d = '0;
    case (ss)
      4'b0001: begin d.ok = 1'b1; d.lg2 = 2'd3; end
      4'b0010: begin d.ok = 1'b1; d.lg2 = 2'd2; end
      4'b0100: begin d.ok = 1'b1; d.lg2 = 2'd1; end
      4'b1000: begin d.ok = 1'b1; d.lg2 = 2'd0; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tri_hit_count_mon_if.sv
// Report channel: valid/ready handshake carrying one per-triangle hit record.
interface tri_hit_count_mon_if;

  logic                       rep_valid_o;
  logic                       rep_ready_i;
  tri_hit_pkg::tri_hit_rec_t  rep_o;

  modport master (output rep_valid_o, output rep_o, input rep_ready_i);
  modport slave  (input rep_valid_o, input rep_o, output rep_ready_i);

endinterface

// File: rtl/tri_hit_fifo.sv
// Synchronous FIFO with registered pointers; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module tri_hit_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  // extra pointer MSB distinguishes full from empty
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/tri_hit_count_mon.sv
// Per-triangle sample-hit counter: re-aligns triangle starts to the hit stream,
// counts hits per triangle and queues one report record per closed triangle.
module tri_hit_count_mon
  import tri_hit_pkg::*;
#(
  parameter int unsigned SIGFIG     = REC_SIGFIG,
  parameter int unsigned VERTS      = REC_VERTS,
  parameter int unsigned CNT_W      = REC_CNT_W,
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               tri_valid_R16H,
  input  logic [VERTS-1:0][1:0][SIGFIG-1:0]  tri_R16S,
  input  logic [3:0]                         subSample_RnnnnU,
  input  logic                               hit_valid_R18H,
  input  logic                               flush_i,
  tri_hit_count_mon_if.master                rep_if,
  output logic [CNT_W-1:0]                   drop_cnt_o,
  output logic [CNT_W-1:0]                   orphan_cnt_o,
  output logic                               cfg_err_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OPEN = 1'b1;

  typedef struct packed {
    logic    v;
    tri_t    vtx;
    ss_dec_t ss;
  } pipe_t;

  pipe_t pipe_q [PIPE_DEPTH];
  pipe_t pipe_out;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, rec_cnt;
  tri_t             vtx_q, vtx_d;
  logic [1:0]       lg2_q, lg2_d;
  logic [CNT_W-1:0] orphan_q, orphan_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             cfg_err_q, cfg_err_d;

  logic             start_d, close, pop, drop;
  logic             fifo_full, fifo_empty;
  tri_hit_rec_t     rec;
  logic [$bits(tri_hit_rec_t)-1:0] fifo_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{v: tri_valid_R16H, vtx: tri_t'(tri_R16S),
                     ss: ss_decode(subSample_RnnnnU)};
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pipe_out = pipe_q[PIPE_DEPTH-1];
  assign start_d  = pipe_out.v;

  assign cnt_inc = (hit_valid_R18H && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  assign close   = (state_q == S_OPEN) && (start_d || flush_i);
  // on a start boundary the concurrent hit belongs to the new triangle
  assign rec_cnt = start_d ? cnt_q : cnt_inc;

  always_comb begin
    rec          = '0;
    rec.vtx      = vtx_q;
    rec.count    = REC_CNT_W'(rec_cnt);
    rec.ss_w_lg2 = lg2_q;
    rec.sat      = &rec_cnt;
  end

  assign pop  = rep_if.rep_valid_o && rep_if.rep_ready_i;
  assign drop = close && fifo_full && !pop;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vtx_d     = vtx_q;
    lg2_d     = lg2_q;
    orphan_d  = orphan_q;
    cfg_err_d = cfg_err_q;
    drop_d    = (drop && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
    if (start_d) begin
      state_d   = S_OPEN;
      cnt_d     = CNT_W'(hit_valid_R18H);
      vtx_d     = pipe_out.vtx;
      lg2_d     = pipe_out.ss.lg2;
      cfg_err_d = cfg_err_q | ~pipe_out.ss.ok;
    end else if (state_q == S_OPEN) begin
      if (flush_i) state_d = S_IDLE;
      else         cnt_d   = cnt_inc;
    end else if (hit_valid_R18H && orphan_q != '1) begin
      orphan_d = orphan_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      vtx_q     <= '0;
      lg2_q     <= '0;
      orphan_q  <= '0;
      drop_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vtx_q     <= vtx_d;
      lg2_q     <= lg2_d;
      orphan_q  <= orphan_d;
      drop_q    <= drop_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  tri_hit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(tri_hit_rec_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (close),
    .data_i  (rec),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rep_if.rep_valid_o = ~fifo_empty;
  assign rep_if.rep_o       = fifo_empty ? '0 : tri_hit_rec_t'(fifo_data);
  assign drop_cnt_o         = drop_q;
  assign orphan_cnt_o       = orphan_q;
  assign cfg_err_o          = cfg_err_q;

endmodule
